// File: rtl/gpu_pkg.sv
// gpu_pkg: shared fetch FSM states and AXI4-lite constants
package gpu_pkg;
  typedef enum logic [2:0] {IDLE, AR_VERT, R_VERT, AR_COLOR, R_COLOR} fetch_state_t;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam int VERTEX_WORDS = 5;
  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;
endpackage

// File: rtl/triangle_fetch_if.sv
// triangle_fetch_if: AXI4-lite bus bundle, master drives aw/w/ar/bready/rready, slave drives the rest
interface triangle_fetch_if #(parameter int MADDR_WIDTH = 32);
  logic [MADDR_WIDTH-1:0] awaddr_m;
  logic [2:0] awprot_m;
  logic awvalid_m;
  logic awready_m;
  logic [31:0] wdata_m;
  logic [3:0] wstrb_m;
  logic wvalid_m;
  logic wready_m;
  logic [1:0] bresp_m;
  logic bvalid_m;
  logic bready_m;
  logic [MADDR_WIDTH-1:0] araddr_m;
  logic [2:0] arprot_m;
  logic arvalid_m;
  logic arready_m;
  logic [31:0] rdata_m;
  logic [1:0] rresp_m;
  logic rvalid_m;
  logic rready_m;
  modport master(
    output awaddr_m, awprot_m, awvalid_m, wdata_m, wstrb_m, wvalid_m, bready_m,
    output araddr_m, arprot_m, arvalid_m, rready_m,
    input awready_m, wready_m, bresp_m, bvalid_m, arready_m, rdata_m, rresp_m, rvalid_m
  );
  modport slave(
    input awaddr_m, awprot_m, awvalid_m, wdata_m, wstrb_m, wvalid_m, bready_m,
    input araddr_m, arprot_m, arvalid_m, rready_m,
    output awready_m, wready_m, bresp_m, bvalid_m, arready_m, rdata_m, rresp_m, rvalid_m
  );
endinterface

// File: rtl/triangle_fetch_axil_read_port.sv
// axil_read_port: single-beat AXI4-lite read (req+addr in; ar_done, done+data+resp out; araddr/arvalid/rready to bus)
module axil_read_port #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic [AW-1:0] addr,
  output logic          ar_done,
  output logic          done,
  output logic [31:0]   data,
  output logic [1:0]    resp,
  output logic [AW-1:0] araddr,
  output logic          arvalid,
  input  logic          arready,
  input  logic [31:0]   rdata,
  input  logic [1:0]    rresp,
  input  logic          rvalid,
  output logic          rready
);
  logic arvalid_d, arvalid_q, rready_d, rready_q;
  logic [AW-1:0] araddr_d, araddr_q;
  assign ar_done = arvalid_q & arready;
  assign done = rready_q & rvalid;
  assign data = rdata;
  assign resp = rresp;
  assign araddr = araddr_q;
  assign arvalid = arvalid_q;
  assign rready = rready_q;
  always_comb begin
    arvalid_d = req | (arvalid_q & ~arready);
    araddr_d = req ? addr : araddr_q;
    rready_d = ar_done | (rready_q & ~rvalid);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      arvalid_q <= 1'b0;
      araddr_q <= '0;
      rready_q <= 1'b0;
    end else begin
      arvalid_q <= arvalid_d;
      araddr_q <= araddr_d;
      rready_q <= rready_d;
    end
  end
endmodule

// File: rtl/triangle_fetch.sv
// triangle_fetch: on start reads 5 vertex words + 1 color word over AXI4-lite into vertexes/colors; eoc=idle/valid, rd_error sticky per fetch
module triangle_fetch
  import gpu_pkg::*;
#(
  parameter int MADDR_WIDTH = 32,
  parameter int COORD_WIDTH = 16,
  parameter int COLOR_WIDTH = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [MADDR_WIDTH-1:0]                addr_vertex,
  input  logic [MADDR_WIDTH-1:0]                addr_colors,
  output logic [2:0][2:0][COORD_WIDTH-1:0]      vertexes,
  output logic [COLOR_WIDTH-1:0]                colors,
  output logic                                  eoc,
  output logic                                  rd_error,
  triangle_fetch_if.master                      m
);
  fetch_state_t state_d, state_q;
  logic [2:0] word_d, word_q;
  logic [MADDR_WIDTH-1:0] addr_v_d, addr_v_q, req_addr;
  logic [MADDR_WIDTH-1:1] addr_c_d, addr_c_q;
  logic [8:0][COORD_WIDTH-1:0] vert_d, vert_q;
  logic [COLOR_WIDTH-1:0] color_d, color_q;
  logic err_d, err_q, req, ar_done, done;
  logic [31:0] data;
  logic [1:0] resp;
  axil_read_port #(.AW(MADDR_WIDTH)) u_rd (
    .clk(clk), .reset(reset), .req(req), .addr(req_addr),
    .ar_done(ar_done), .done(done), .data(data), .resp(resp),
    .araddr(m.araddr_m), .arvalid(m.arvalid_m), .arready(m.arready_m),
    .rdata(m.rdata_m), .rresp(m.rresp_m), .rvalid(m.rvalid_m), .rready(m.rready_m)
  );
  assign m.awaddr_m = '0;
  assign m.awprot_m = AXI_PROT_DEFAULT;
  assign m.awvalid_m = 1'b0;
  assign m.wdata_m = '0;
  assign m.wstrb_m = '0;
  assign m.wvalid_m = 1'b0;
  assign m.bready_m = 1'b1;
  assign m.arprot_m = AXI_PROT_DEFAULT;
  assign vertexes = vert_q;
  assign colors = color_q;
  assign eoc = state_q == IDLE;
  assign rd_error = err_q;
  always_comb begin
    state_d = state_q;
    word_d = word_q;
    addr_v_d = addr_v_q;
    addr_c_d = addr_c_q;
    vert_d = vert_q;
    color_d = color_q;
    err_d = err_q | (done & (resp != AXI_RESP_OKAY));
    req = 1'b0;
    req_addr = addr_v_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = AR_VERT;
        word_d = '0;
        err_d = 1'b0;
        addr_v_d = addr_vertex;
        addr_c_d = addr_colors[MADDR_WIDTH-1:1];
        req = 1'b1;
        req_addr = addr_vertex;
      end
      AR_VERT: state_d = ar_done ? R_VERT : AR_VERT;
      R_VERT: if (done) begin
        // word w carries halfwords 2w (low) and 2w+1 (high); halfword 9 has no slot
        for (int i = 0; i < 9; i++)
          if (word_q == 3'(i >> 1)) vert_d[i] = COORD_WIDTH'((i % 2 == 1) ? data[31:16] : data[15:0]);
        req = 1'b1;
        if (word_q == 3'(VERTEX_WORDS - 1)) begin
          state_d = AR_COLOR;
          req_addr = {addr_c_q[MADDR_WIDTH-1:2], 2'b00};
        end else begin
          state_d = AR_VERT;
          word_d = word_q + 3'd1;
          req_addr = addr_v_q + MADDR_WIDTH'({word_q + 3'd1, 2'b00});
        end
      end
      AR_COLOR: state_d = ar_done ? R_COLOR : AR_COLOR;
      R_COLOR: if (done) begin
        color_d = COLOR_WIDTH'(addr_c_q[1] ? data[31:16] : data[15:0]);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      word_q <= '0;
      addr_v_q <= '0;
      addr_c_q <= '0;
      vert_q <= '0;
      color_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q <= word_d;
      addr_v_q <= addr_v_d;
      addr_c_q <= addr_c_d;
      vert_q <= vert_d;
      color_q <= color_d;
      err_q <= err_d;
    end
  end
endmodule
